// File: rtl/push_packet_rx_pkg.sv
// push_pkt_pkg: definitions shared by the push-packet sender and receiver.
//   state_e     : receiver FSM states.
//   CRC8_POLY   : CRC-8 generator polynomial (x^8 + x^2 + x + 1).
//   CRC8_INIT   : CRC seed for the first word of a packet.
//   CRC_MAX_W   : widest word crc8_word accepts.
//   crc8_word() : folds one word into a running CRC-8, MSB first.
package push_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_CRC = 2'd2,
        HOLD     = 2'd3
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int         CRC_MAX_W = 64;

    // Bit-serial CRC-8, no reflection and no final XOR. Only the low
    // 'width' bits of data are processed, starting from bit width-1.
    function automatic logic [7:0] crc8_word(input logic [7:0]           crc,
                                             input logic [CRC_MAX_W-1:0] data,
                                             input int                   width);
        logic [7:0] c;
        logic       fb;
        c  = crc;
        fb = 1'b0;
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                fb = c[7] ^ data[i];
                c  = {c[6:0], 1'b0};
                if (fb) begin
                    c = c ^ CRC8_POLY;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/push_packet_rx_if.sv
// push_packet_rx_if: link-side push handshake plus consumer-side packet
// handshake of the push-packet receiver.
//   in_valid/in_data/in_ready    : word push from the sender.
//   out_valid/out_ready          : packet hand-off to the consumer.
//   pkt_a/pkt_b                  : held packet contents.
//   finish_strb/crc_err/timeout_err : one-cycle status pulses.
// Modports: slave = receiver block, master = sender/consumer side.
interface push_packet_rx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] pkt_a;
    logic [DATA_W-1:0] pkt_b;
    logic              finish_strb;
    logic              crc_err;
    logic              timeout_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, pkt_a, pkt_b, finish_strb, crc_err, timeout_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, pkt_a, pkt_b, finish_strb, crc_err, timeout_err
    );
endinterface

// File: rtl/push_packet_rx_timeout_cnt.sv
// push_pkt_timeout_cnt: idle-cycle counter with clear, enable and a
// reach-limit flag. The count saturates at LIMIT so it can never wrap.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset.
//   clr       : force the count to zero (wins over en).
//   en        : count one more idle cycle.
//   at_limit  : count currently equals LIMIT.
module push_pkt_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic at_limit
);
    localparam int               CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, counting stops at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_C);
endmodule

// File: rtl/push_packet_rx.sv
// push_packet_rx: receives A, B, CRC words pushed by the sender, checks the
// CRC-8 over A and B, and holds (A, B) for the consumer until taken.
// Aborts a partial packet after TIMEOUT idle cycles between words.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset.
//   bus       : push_packet_rx_if.slave (push handshake, packet handshake,
//               pkt_a/pkt_b, finish_strb/crc_err/timeout_err pulses).
// Build option: PUSH_PACKET_RX_CRC_CHECK_EN builds the CRC checker; without
// it the CRC word is consumed unchecked and crc_err is tied low.
module push_packet_rx
    import push_pkt_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rstn,
    push_packet_rx_if.slave  bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] pkt_a_q, pkt_a_d;
    logic [DATA_W-1:0] pkt_b_q, pkt_b_d;
    logic              out_valid_q, out_valid_d;
    logic              finish_strb_q, finish_strb_d;
    logic              timeout_err_q, timeout_err_d;

    logic in_ready_s;
    logic in_xfer_s;
    logic waiting_s;
    logic cnt_at_limit_s;
    logic cnt_clr_s;
    logic timeout_fire_s;

    // Ready is a state decode, held low while reset is asserted.
    assign in_ready_s     = rstn && (state_q != HOLD);
    assign in_xfer_s      = bus.in_valid && in_ready_s;
    assign waiting_s      = (state_q == WAIT_B) || (state_q == WAIT_CRC);
    // A transfer in the limit cycle wins over the timeout.
    assign timeout_fire_s = waiting_s && !in_xfer_s && cnt_at_limit_s;
    assign cnt_clr_s      = !waiting_s || in_xfer_s || timeout_fire_s;

    push_pkt_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (cnt_clr_s),
        .en       (waiting_s),
        .at_limit (cnt_at_limit_s)
    );

`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
    logic [7:0]           crc_q, crc_d;
    logic                 crc_err_q, crc_err_d;
    logic [7:0]           crc_next_s;
    logic [CRC_MAX_W-1:0] data_ext_s;

    // Zero-extend the incoming word to the CRC helper's argument width.
    always_comb begin
        data_ext_s              = '0;
        data_ext_s[DATA_W-1:0]  = bus.in_data;
    end

    // Word A starts from the seed; word B extends the running CRC.
    assign crc_next_s = crc8_word((state_q == IDLE) ? CRC8_INIT : crc_q, data_ext_s, DATA_W);
`endif

    // Next-state and next-output logic of the receive FSM.
    always_comb begin
        state_d       = state_q;
        pkt_a_d       = pkt_a_q;
        pkt_b_d       = pkt_b_q;
        out_valid_d   = out_valid_q;
        finish_strb_d = 1'b0;
        timeout_err_d = 1'b0;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
        crc_d         = crc_q;
        crc_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_xfer_s) begin
                    pkt_a_d = bus.in_data;
                    state_d = WAIT_B;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
                    crc_d   = crc_next_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_B: begin
                if (in_xfer_s) begin
                    pkt_b_d = bus.in_data;
                    state_d = WAIT_CRC;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
                    crc_d   = crc_next_s;
`endif
                end else if (timeout_fire_s) begin
                    // pkt_a keeps its partial value; it is not presented.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
                    crc_d         = CRC8_INIT;
`endif
                end else begin
                    state_d = WAIT_B;
                end
            end
            WAIT_CRC: begin
                if (in_xfer_s) begin
                    finish_strb_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
                    crc_err_d     = (crc_q != bus.in_data[7:0]);
                    crc_d         = CRC8_INIT;
`endif
                end else if (timeout_fire_s) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
                    crc_d         = CRC8_INIT;
`endif
                end else begin
                    state_d = WAIT_CRC;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            pkt_a_q       <= '0;
            pkt_b_q       <= '0;
            out_valid_q   <= 1'b0;
            finish_strb_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkt_a_q       <= pkt_a_d;
            pkt_b_q       <= pkt_b_d;
            out_valid_q   <= out_valid_d;
            finish_strb_q <= finish_strb_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
    // Running CRC and error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q     <= CRC8_INIT;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign bus.crc_err = crc_err_q;
`else
    assign bus.crc_err = 1'b0;
`endif

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.pkt_a       = pkt_a_q;
    assign bus.pkt_b       = pkt_b_q;
    assign bus.finish_strb = finish_strb_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_push_packet_rx.sv
// tb_push_packet_rx: directed and randomized stimulus for push_packet_rx,
// compared every cycle against a queue-based packet model; the CRC
// reference uses polynomial long division over the message {A, B}.
module tb_push_packet_rx;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;
`ifdef PUSH_PACKET_RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    push_packet_rx_if #(.DATA_W(DATA_W)) bus ();

    push_packet_rx #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // consumer ready: fixed level or random per cycle
    logic or_val       = 1'b0;
    logic or_rand_mode = 1'b0;
    logic or_rand      = 1'b0;
    assign bus.out_ready = or_rand_mode ? or_rand : or_val;
    always @(negedge clk) or_rand <= 1'($urandom_range(0, 1));

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-8 as remainder of ({A,B} * x^8) mod (x^8 + x^2 + x + 1).
    function automatic logic [7:0] ref_crc(input logic [7:0] a, input logic [7:0] b);
        logic [23:0] r;
        r = {a, b, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r = r ^ (24'h000107 << (i - 8));
        end
        return r[7:0];
    endfunction

    // what the DUT saw at each rising edge
    logic       s_rstn_hi   = 1'b0;
    logic       s_in_valid  = 1'b0;
    logic [7:0] s_in_data   = 8'h00;
    logic       s_out_ready = 1'b0;
    always @(posedge clk) begin
        s_rstn_hi   <= rstn;
        s_in_valid  <= bus.in_valid;
        s_in_data   <= bus.in_data;
        s_out_ready <= bus.out_ready;
    end

    // packet-level model
    logic [7:0] m_words[$];
    int         m_gap  = 0;
    bit         m_hold = 1'b0;
    logic       e_fin  = 1'b0;
    logic       e_crc  = 1'b0;
    logic       e_to   = 1'b0;
    logic [7:0] e_a    = 8'h00;
    logic [7:0] e_b    = 8'h00;
    int         dut_fin = 0;
    int         dut_to  = 0;

    // Advance the model by the last edge, then compare every output.
    always @(negedge clk) begin
        e_fin = 1'b0;
        e_crc = 1'b0;
        e_to  = 1'b0;
        if (!rstn) begin
            m_words.delete();
            m_gap  = 0;
            m_hold = 1'b0;
            e_a    = 8'h00;
            e_b    = 8'h00;
        end else if (s_rstn_hi) begin
            if (m_hold) begin
                if (s_out_ready) m_hold = 1'b0;
            end else if (s_in_valid) begin
                m_words.push_back(s_in_data);
                m_gap = 0;
                if (m_words.size() == 1) e_a = s_in_data;
                else if (m_words.size() == 2) e_b = s_in_data;
                else begin
                    e_fin  = 1'b1;
                    e_crc  = CRC_ON && (ref_crc(m_words[0], m_words[1]) != m_words[2]);
                    m_hold = 1'b1;
                    m_words.delete();
                end
            end else if (m_words.size() != 0) begin
                if (m_gap == TIMEOUT) begin
                    e_to = 1'b1;
                    m_words.delete();
                    m_gap = 0;
                end else begin
                    m_gap++;
                end
            end
        end
        check1("in_ready", bus.in_ready, rstn && !m_hold);
        check1("out_valid", bus.out_valid, m_hold);
        check1("finish_strb", bus.finish_strb, e_fin);
        check1("crc_err", bus.crc_err, e_crc);
        check1("timeout_err", bus.timeout_err, e_to);
        if (m_hold || !rstn) begin
            check8("pkt_a", bus.pkt_a, e_a);
            check8("pkt_b", bus.pkt_b, e_b);
        end
        if (bus.finish_strb === 1'b1) dut_fin++;
        if (bus.timeout_err === 1'b1) dut_to++;
    end

    // Idle 'gap' cycles, then offer d until accepted (returns one negedge after the transfer edge).
    task automatic push_word(input logic [7:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 64; k++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check1("push_accept", ok, 1'b1);
    endtask

    task automatic push_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input int ga, input int gb, input int gc);
        push_word(a, ga);
        push_word(b, gb);
        push_word(c, gc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int to_at;
        int fin0;
        int to0;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check8("rst_pkt_a", bus.pkt_a, 8'h00);
        check1("rst_timeout_err", bus.timeout_err, 1'b0);
        check8("model_crc_0001", ref_crc(8'h00, 8'h01), 8'h07);
        check8("model_crc_0100", ref_crc(8'h01, 8'h00), 8'h15);
        #2 rstn = 1'b1;
        @(negedge clk);
        check1("idle_in_ready", bus.in_ready, 1'b1);

        // good packet, consumer always ready
        or_val = 1'b1;
        push_pkt(8'h00, 8'h01, 8'h07, 0, 0, 0);
        check1("t1_finish", bus.finish_strb, 1'b1);
        check1("t1_crc_err", bus.crc_err, 1'b0);
        check1("t1_out_valid", bus.out_valid, 1'b1);
        check8("t1_pkt_a", bus.pkt_a, 8'h00);
        check8("t1_pkt_b", bus.pkt_b, 8'h01);
        @(negedge clk);
        check1("t1_out_valid_drop", bus.out_valid, 1'b0);

        // bad CRC still delivered
        push_pkt(8'h00, 8'h01, 8'h08, 0, 0, 0);
        check1("t2_finish", bus.finish_strb, 1'b1);
        check1("t2_crc_err", bus.crc_err, CRC_ON);
        check8("t2_pkt_b", bus.pkt_b, 8'h01);
        @(negedge clk);

        // consumer stall: packet held, sender blocked, no timeout
        or_val = 1'b0;
        push_pkt(8'hA5, 8'h5A, ref_crc(8'hA5, 8'h5A), 0, 0, 0);
        to0 = dut_to;
        repeat (10) @(negedge clk);
        check1("hold_out_valid", bus.out_valid, 1'b1);
        check1("hold_in_ready", bus.in_ready, 1'b0);
        check8("hold_pkt_a", bus.pkt_a, 8'hA5);
        fork
            push_word(8'h11, 0);
            begin
                repeat (3) @(negedge clk);
                or_val = 1'b1;
            end
        join
        push_word(8'h22, 0);
        push_word(ref_crc(8'h11, 8'h22), 0);
        check1("hold_next_finish", bus.finish_strb, 1'b1);
        checki("hold_no_timeout", dut_to - to0, 0);
        @(negedge clk);

        // timeout after word A
        push_word(8'h77, 0);
        to_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.timeout_err === 1'b1 && to_at == 0) to_at = k;
        end
        checki("timeout_cycle", to_at, TIMEOUT + 1);
        check1("timeout_in_ready", bus.in_ready, 1'b1);

        // words arriving exactly at the limit win
        to0 = dut_to;
        push_word(8'h78, 0);
        push_word(8'h79, TIMEOUT);
        push_word(ref_crc(8'h78, 8'h79), TIMEOUT);
        check1("boundary_finish", bus.finish_strb, 1'b1);
        check8("boundary_pkt_b", bus.pkt_b, 8'h79);
        @(negedge clk);
        checki("boundary_no_timeout", dut_to - to0, 0);

        // reset in WAIT_CRC
        push_word(8'h5A, 0);
        push_word(8'h3C, 0);
        #2 rstn = 1'b0;
        #1;
        check1("mid_rst_in_ready", bus.in_ready, 1'b0);
        check1("mid_rst_out_valid", bus.out_valid, 1'b0);
        check1("mid_rst_finish", bus.finish_strb, 1'b0);
        check1("mid_rst_crc_err", bus.crc_err, 1'b0);
        check1("mid_rst_timeout", bus.timeout_err, 1'b0);
        check8("mid_rst_pkt_a", bus.pkt_a, 8'h00);
        check8("mid_rst_pkt_b", bus.pkt_b, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        push_pkt(8'h12, 8'h34, ref_crc(8'h12, 8'h34), 0, 0, 0);
        check1("post_rst_finish", bus.finish_strb, 1'b1);
        check1("post_rst_crc_err", bus.crc_err, 1'b0);
        check8("post_rst_pkt_a", bus.pkt_a, 8'h12);
        @(negedge clk);

        // random packets with gaps below the limit, random consumer
        or_rand_mode = 1'b1;
        fin0 = dut_fin;
        to0  = dut_to;
        for (int p = 0; p < 100; p++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = ref_crc(a, b);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            push_pkt(a, b, c, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                     int'($urandom_range(0, 14)));
        end
        @(negedge clk);
        checki("rand_finishes", dut_fin - fin0, 100);
        checki("rand_timeouts", dut_to - to0, 0);
        or_rand_mode = 1'b0;
        or_val       = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
